alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter XLEN, default 32: operand/result width, power of two, minimum 8.
REQ-002 Parameter SHW, default $clog2(XLEN): shift-amount width; derived, not overridden.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous abort of any in-flight operation.
REQ-006 in_valid  input  1  operation request.
REQ-007 in_ready  output  1  unit accepts a request this cycle.
REQ-008 alu_op  input  5  operation code (REQ-012).
REQ-009 a, b  input  XLEN each  operands; b[SHW-1:0] is the shift amount.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts the result; y  output  XLEN  result.

Function
REQ-012 Op codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULH, 12 MULHU, 13 DIV, 14 DIVU, 15 REM, 16 REMU; codes 17-31 yield y=0 with simple-class timing.
REQ-013 FSM states SHALL be IDLE, BUSY, DONE; in_ready = (state==IDLE) && !flush.
REQ-014 Acceptance SHALL occur on a cycle with in_valid && in_ready; operands and op are captured then and are not sampled again.
REQ-015 Simple class (0-9 and 17-31): IDLE -> DONE; out_valid is asserted on the first cycle after acceptance.
REQ-016 Iterative class (10-16): IDLE -> BUSY, counter runs XLEN cycles, BUSY -> DONE; out_valid is asserted exactly XLEN+1 cycles after acceptance.
REQ-017 Iterative latency SHALL be fixed and independent of operand values, including the special cases.
REQ-018 In DONE, out_valid and y SHALL hold stable until out_ready; DONE && out_ready -> IDLE, with out_valid low the next cycle.
REQ-019 No new request is accepted in the DONE-exit cycle; maximum throughput is one simple op per 2 cycles.
REQ-020 Arithmetic SHALL wrap modulo 2^XLEN; SLT/SRA/MULH/DIV/REM are signed, all others unsigned; SLT/SLTU yield 1 or 0.
REQ-021 MUL SHALL return the low XLEN bits; MULH/MULHU return the high XLEN bits of the 2*XLEN product.
REQ-022 Signed MULH/DIV/REM SHALL operate on magnitudes and then correct the sign: quotient negative iff operand signs differ; remainder takes the sign of the dividend.
REQ-023 Divide by zero: DIV/DIVU yield all-ones; REM/REMU yield a.
REQ-024 Signed overflow (a = -2^(XLEN-1), b = -1): DIV yields a; REM yields 0.
REQ-025 flush SHALL force IDLE on the next edge from any state, drop out_valid, discard the result, and block acceptance in the same cycle.

Reset
REQ-026 On rst_n low, the unit SHALL immediately enter IDLE with out_valid=0, y=0, counter=0 and internal operand registers cleared.
REQ-027 Reset asserted mid-operation SHALL abandon that operation; after release, in_ready=1 with no spurious out_valid.

Structure
REQ-028 Package alu_pkg SHALL hold the op-code localparams, the state typedef (IDLE/BUSY/DONE) and the op-class decode function.
REQ-029 Iterative multiply (shift-add) and divide (restoring) SHALL live in sub-module alu_muldiv_iter, parameterised by XLEN, with start/done ports.
REQ-030 Simple-class results SHALL be computed combinationally from the captured operands in alu_mc and registered into y.

Verification
REQ-031 ADD 0xFFFFFFFF + 1, out_ready=1 -> y=0 with out_valid exactly 1 cycle after acceptance; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-032 MULH 0xFFFFFFFF * 0xFFFFFFFF -> y=0 at cycle 33; MULHU on the same operands -> 0xFFFFFFFE; MUL 7*(-3) -> 0xFFFFFFEB.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; all four at cycle 33.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; out_ready held low 5 cycles -> y and out_valid stable throughout.
REQ-035 flush at BUSY cycle 10 together with in_valid=1 -> no acceptance, no out_valid, in_ready=1 next cycle; rst_n pulse mid-DIVU -> immediate IDLE.
REQ-036 Rerun with XLEN=16: MULHU 0xFFFF*0xFFFF -> 0xFFFE at cycle 17; SLL by b=0x0013 shifts by 3.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM state type and op-class decode for alu_mc
// Contents: OP_* op-code constants, state_t (IDLE/BUSY/DONE), is_iter_op().
package alu_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_SLL   = 5'd5;
  localparam logic [4:0] OP_SRL   = 5'd6;
  localparam logic [4:0] OP_SRA   = 5'd7;
  localparam logic [4:0] OP_SLT   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
  localparam logic [4:0] OP_MUL   = 5'd10;
  localparam logic [4:0] OP_MULH  = 5'd11;
  localparam logic [4:0] OP_MULHU = 5'd12;
  localparam logic [4:0] OP_DIV   = 5'd13;
  localparam logic [4:0] OP_DIVU  = 5'd14;
  localparam logic [4:0] OP_REM   = 5'd15;
  localparam logic [4:0] OP_REMU  = 5'd16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply/divide family takes the multi-cycle path; everything else,
  // including the undefined codes, completes in one cycle.
  function automatic logic is_iter_op(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - fixed-latency shift-add multiplier and restoring divider
// Ports: clk, rst_n (async, active-low), flush, start (load a/b/op),
//        op, a, b, done (pulse on final step), result (valid while done).
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic              busy;
  logic [CW-1:0]     cnt;
  logic [4:0]        op_q;
  logic              neg_q;
  logic              div0_q;
  // Multiply: {partial product high, remaining multiplier}.
  // Divide:   {partial remainder, dividend bits / quotient bits}.
  logic [2*XLEN-1:0] p_q;
  logic [XLEN-1:0]   d_q;

  logic              signed_op, sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next, p_next, prod;
  logic [XLEN-1:0]   lo, hi, quo, rem;

  // Signed ops work on magnitudes; neg_q records the sign to restore.
  always_comb begin
    signed_op = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sa        = signed_op & a[XLEN-1];
    sb        = signed_op & b[XLEN-1];
    a_mag     = sa ? -a : a;
    b_mag     = sb ? -b : b;
  end

  always_comb begin
    mul_sum   = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, d_q} : {(XLEN+1){1'b0}});
    mul_next  = {mul_sum, p_q[XLEN-1:1]};
    div_shift = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    div_trial = div_shift - {1'b0, d_q};
    div_next  = div_trial[XLEN] ? {div_shift[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
    p_next    = (op_q <= OP_MULHU) ? mul_next : div_next;
  end

  // Result is taken from the state the last step produces, so the top can
  // register it on the same edge that step would have been stored.
  always_comb begin
    prod   = neg_q ? -p_next : p_next;
    lo     = p_next[XLEN-1:0];
    hi     = p_next[2*XLEN-1:XLEN];
    quo    = neg_q ? -lo : lo;
    rem    = neg_q ? -hi : hi;
    done   = busy && (cnt == CW'(XLEN - 1));
    result = '0;
    case (op_q)
      OP_MUL:             result = prod[XLEN-1:0];
      OP_MULH, OP_MULHU:  result = prod[2*XLEN-1:XLEN];
      // Divide by zero leaves the dividend magnitude in the remainder,
      // so only the quotient needs overriding.
      OP_DIV, OP_DIVU:    result = div0_q ? '1 : quo;
      OP_REM, OP_REMU:    result = rem;
      default:            result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      div0_q <= 1'b0;
      p_q    <= '0;
      d_q    <= '0;
    end else if (flush) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      op_q   <= op;
      neg_q  <= (op == OP_REM) ? sa : (sa ^ sb);
      div0_q <= (b == '0);
      p_q    <= {{XLEN{1'b0}}, a_mag};
      d_q    <= b_mag;
    end else if (busy) begin
      p_q <= p_next;
      cnt <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready request and result handshakes
// Ports: clk, rst_n (async, active-low), flush, in_valid/in_ready, alu_op, a, b,
//        out_valid/out_ready, y.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] y
);

  state_t          state;
  logic            accept, start_iter, iter_done;
  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] simple_res, iter_res;

  assign in_ready   = (state == IDLE) && !flush;
  assign accept     = in_valid && in_ready;
  assign start_iter = accept && is_iter_op(alu_op);
  assign sh         = b[SHW-1:0];

  // Evaluated on the operands being captured so the single-cycle ops can
  // register y on the acceptance edge.
  always_comb begin
    simple_res = '0;
    case (alu_op)
      OP_ADD:  simple_res = a + b;
      OP_SUB:  simple_res = a - b;
      OP_AND:  simple_res = a & b;
      OP_OR:   simple_res = a | b;
      OP_XOR:  simple_res = a ^ b;
      OP_SLL:  simple_res = a << sh;
      OP_SRL:  simple_res = a >> sh;
      OP_SRA:  simple_res = $unsigned($signed(a) >>> sh);
      OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: simple_res = {{(XLEN-1){1'b0}}, (a < b)};
      default: simple_res = '0;
    endcase
  end

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (start_iter),
    .op     (alu_op),
    .a      (a),
    .b      (b),
    .done   (iter_done),
    .result (iter_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      y         <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_iter_op(alu_op)) begin
              state <= BUSY;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              y         <= simple_res;
            end
          end
        end
        BUSY: begin
          if (iter_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            y         <= iter_res;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed scoreboard bench for alu_mc at XLEN=32 and XLEN=16
module tb_alu_mc;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, out_ready;
  logic        iv32, ir32, ov32;
  logic [4:0]  op32;
  logic [31:0] a32, b32, y32;
  logic        iv16, ir16, ov16;
  logic [4:0]  op16;
  logic [15:0] a16, b16, y16;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] val;
    string       tag;
  } exp_t;
  exp_t sb[$];

  alu_mc #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv32), .in_ready(ir32),
    .alu_op(op32), .a(a32), .b(b32), .out_valid(ov32), .out_ready(out_ready), .y(y32)
  );

  alu_mc #(.XLEN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv16), .in_ready(ir16),
    .alu_op(op16), .a(a16), .b(b16), .out_valid(ov16), .out_ready(out_ready), .y(y16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the selected DUT idle. Drives one request,
  // waits for the result, optionally stalls out_ready for 'hold' cycles.
  task automatic run_op(input bit w16, input logic [4:0] op, input logic [31:0] x,
                        input logic [31:0] z, input logic [31:0] ev, input int hold,
                        input string tag);
    int   lat, cyc;
    exp_t e;
    lat = ((op >= 5'd10) && (op <= 5'd16)) ? (w16 ? 17 : 33) : 1;
    out_ready = (hold == 0);
    check({tag, "/in_ready"}, {31'b0, (w16 ? ir16 : ir32)}, 32'd1);
    if (w16) begin
      iv16 = 1'b1; op16 = op; a16 = x[15:0]; b16 = z[15:0];
    end else begin
      iv32 = 1'b1; op32 = op; a32 = x; b32 = z;
    end
    sb.push_back('{ev, tag});
    @(negedge clk);
    // Scramble inputs after acceptance: the DUT must not resample them.
    iv16 = 1'b0; iv32 = 1'b0;
    a32 = $urandom; b32 = $urandom; op32 = 5'($urandom_range(0, 31));
    a16 = 16'($urandom); b16 = 16'($urandom); op16 = 5'($urandom_range(0, 31));
    cyc = 1;
    while (!(w16 ? ov16 : ov32) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "/latency"}, 32'(cyc), 32'(lat));
    e = sb.pop_front();
    check({e.tag, "/y"}, w16 ? {16'b0, y16} : y32, e.val);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/hold_valid"}, {31'b0, (w16 ? ov16 : ov32)}, 32'd1);
      check({tag, "/hold_y"}, w16 ? {16'b0, y16} : y32, e.val);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "/exit_valid"}, {31'b0, (w16 ? ov16 : ov32)}, 32'd0);
    check({tag, "/exit_ready"}, {31'b0, (w16 ? ir16 : ir32)}, 32'd1);
  endtask

  // Watch for any out_valid on the 32-bit unit over n cycles.
  task automatic quiet32(input int n, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ov32) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    iv32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    iv16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    #1;
    check("reset/out_valid", {31'b0, ov32}, 32'd0);
    check("reset/y", y32, 32'd0);
    check("reset/in_ready", {31'b0, ir32}, 32'd1);
    check("reset16/y", {16'b0, y16}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, "add_wrap");
    run_op(1'b0, OP_SUB,   32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, "sub_wrap");
    run_op(1'b0, OP_XOR,   32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 0, "xor");
    run_op(1'b0, OP_SRA,   32'h80000000, 32'h00000004, 32'hF8000000, 0, "sra");
    run_op(1'b0, OP_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, "slt");
    run_op(1'b0, OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, "sltu");
    run_op(1'b0, 5'd20,    32'h00000005, 32'h00000006, 32'h00000000, 0, "undef_op");
    run_op(1'b0, OP_MULH,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, "mulh");
    run_op(1'b0, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "mulhu");
    run_op(1'b0, OP_MUL,   32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 0, "mul");
    run_op(1'b0, OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, "div_ovf");
    run_op(1'b0, OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, "rem_ovf");
    run_op(1'b0, OP_DIVU,  32'h00000005, 32'h00000000, 32'hFFFFFFFF, 0, "divu_zero");
    run_op(1'b0, OP_REMU,  32'h00000005, 32'h00000000, 32'h00000005, 0, "remu_zero");
    run_op(1'b0, OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 0, "div_zero");
    run_op(1'b0, OP_REM,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 0, "rem_zero");
    run_op(1'b0, OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 0, "div_neg");
    run_op(1'b0, OP_REM,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 5, "rem_neg_hold");

    // Flush in BUSY cycle 10 with a competing request.
    iv32 = 1'b1; op32 = OP_DIVU; a32 = 32'd100; b32 = 32'd7;
    @(negedge clk);
    iv32 = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1; iv32 = 1'b1; op32 = OP_ADD; a32 = 32'd1; b32 = 32'd2;
    #1;
    check("flush/in_ready_blocked", {31'b0, ir32}, 32'd0);
    @(negedge clk);
    flush = 1'b0; iv32 = 1'b0;
    #1;
    check("flush/out_valid", {31'b0, ov32}, 32'd0);
    check("flush/in_ready_after", {31'b0, ir32}, 32'd1);
    quiet32(40, "flush/no_result");
    run_op(1'b0, OP_ADD, 32'h00000010, 32'h00000020, 32'h00000030, 0, "add_after_flush");

    // Reset pulse in the middle of a DIVU.
    iv32 = 1'b1; op32 = OP_DIVU; a32 = 32'd1000; b32 = 32'd3;
    @(negedge clk);
    iv32 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid/out_valid", {31'b0, ov32}, 32'd0);
    check("rst_mid/y", y32, 32'd0);
    check("rst_mid/in_ready", {31'b0, ir32}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid/in_ready_after", {31'b0, ir32}, 32'd1);
    quiet32(40, "rst_mid/no_result");
    run_op(1'b0, OP_DIVU, 32'd1000, 32'd3, 32'd333, 0, "divu_after_rst");

    run_op(1'b1, OP_MULHU, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFE, 0, "x16_mulhu");
    run_op(1'b1, OP_SLL,   32'h00001234, 32'h00000013, 32'h000091A0, 0, "x16_sll");

    check("scoreboard/empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
